// File: rtl/multi_cycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer: FSM states, ISA opcodes,
// ALU operation and ALU source-B select codes.
package multi_cycle_sequencer_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_R_WB      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_BRANCH    = 4'd8,
        S_ILLEGAL   = 4'd9,
        S_BUS_ERR   = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // States that wait on memReady and are therefore guarded by the timer.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multi_cycle_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the shared
// datapath plus memory (slave).
interface multi_cycle_sequencer_if;

    logic [5:0] opCode;
    logic       zero;
    logic       memReady;

    logic       pcWrite;
    logic       pcSrc;
    logic       irWrite;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       retire;
    logic       illegalOp;
    logic       busError;
    logic [3:0] state;

    modport master (
        input  opCode, zero, memReady,
        output pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, memToReg,
               regWrite, regDst, aluSrcA, aluSrcB, aluOp, retire,
               illegalOp, busError, state
    );

    modport slave (
        output opCode, zero, memReady,
        input  pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, memToReg,
               regWrite, regDst, aluSrcA, aluSrcB, aluOp, retire,
               illegalOp, busError, state
    );

endinterface

// File: rtl/multi_cycle_sequencer_mem_wait_timer.sv
// Counts memReady-low cycles in a memory-wait state and flags a timeout once
// MAX_WAIT such cycles have elapsed; MAX_WAIT=0 disables the timeout.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic memReady,
    input  logic active,
    output logic timeout
);

    localparam int              CW     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0]   LIMIT  = CW'(MAX_WAIT);
    localparam logic            ENABLE = (MAX_WAIT > 0);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LIMIT so a long stall never wraps back to a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !memReady && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = ENABLE && active && !memReady && (cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle control FSM for the shared-ALU/shared-memory datapath running
// R-format, LW, SW and BEQ, with sticky traps for bad opcodes and bus stalls.
module multi_cycle_sequencer
    import multi_cycle_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_cycle_sequencer_if.master bus
);

    state_e     state_q, state_d;
    logic [5:0] opLatch_q;
    logic       wait_active, wait_clear, timeout;

    logic       pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite;
    logic       memToReg, regWrite, regDst, aluSrcA, retire;
    logic       illegalOp, busError;
    logic [1:0] aluSrcB, aluOp;

    assign wait_active = is_mem_wait_state(state_q);
    // Any state change re-arms the timer, including MEM_WRITE -> FETCH.
    assign wait_clear  = (state_d != state_q);

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .memReady (bus.memReady),
        .active   (wait_active),
        .timeout  (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.memReady)  state_d = S_DECODE;
                else if (timeout)  state_d = S_BUS_ERR;
            end
            S_DECODE: begin
                case (bus.opCode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_MEM_ADDR:  state_d = (opLatch_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (bus.memReady)  state_d = S_MEM_WB;
                else if (timeout)  state_d = S_BUS_ERR;
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.memReady)  state_d = S_FETCH;
                else if (timeout)  state_d = S_BUS_ERR;
            end
            S_BRANCH:    state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            S_BUS_ERR:   state_d = S_BUS_ERR;
            default:     state_d = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opLatch_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opLatch_q <= bus.opCode;
            end
        end
    end

    // Moore decode of the state register; irWrite/pcWrite/retire may be
    // qualified by memReady or zero, and strobes are held off during reset.
    always_comb begin
        pcWrite   = 1'b0;
        pcSrc     = 1'b0;
        irWrite   = 1'b0;
        iOrD      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        regDst    = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = SRCB_RT;
        aluOp     = ALU_ADD;
        retire    = 1'b0;
        illegalOp = 1'b0;
        busError  = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = bus.memReady;
                pcWrite = bus.memReady;
            end
            S_DECODE:    aluSrcB = SRCB_IMM_SH;
            S_EXEC_R: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
                retire   = bus.memReady;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_SUB;
                pcSrc   = 1'b1;
                pcWrite = bus.zero;
                retire  = 1'b1;
            end
            S_ILLEGAL:   illegalOp = 1'b1;
            S_BUS_ERR:   busError  = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            pcWrite  = 1'b0;
            irWrite  = 1'b0;
            regWrite = 1'b0;
            memWrite = 1'b0;
            memRead  = 1'b0;
            retire   = 1'b0;
        end
    end

    assign bus.pcWrite   = pcWrite;
    assign bus.pcSrc     = pcSrc;
    assign bus.irWrite   = irWrite;
    assign bus.iOrD      = iOrD;
    assign bus.memRead   = memRead;
    assign bus.memWrite  = memWrite;
    assign bus.memToReg  = memToReg;
    assign bus.regWrite  = regWrite;
    assign bus.regDst    = regDst;
    assign bus.aluSrcA   = aluSrcA;
    assign bus.aluSrcB   = aluSrcB;
    assign bus.aluOp     = aluOp;
    assign bus.retire    = retire;
    assign bus.illegalOp = illegalOp;
    assign bus.busError  = busError;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: each stimulus cycle queues its
// expected state/outputs; a negedge monitor pops and compares.
module tb_multi_cycle_sequencer;

    typedef struct packed {
        logic [3:0] st;
        logic       pcWrite;
        logic       pcSrc;
        logic       irWrite;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       retire;
        logic       illegalOp;
        logic       busError;
    } obs_t;

    typedef struct {
        obs_t exp;
        int   id;
    } sb_item_t;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b000001;
    localparam logic [5:0] SW  = 6'b000010;
    localparam logic [5:0] BEQ = 6'b000011;
    localparam logic [5:0] BAD = 6'b000111;

    logic clk = 1'b0;
    logic rst_n;

    multi_cycle_sequencer_if bus ();

    multi_cycle_sequencer #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    sb_item_t sb[$];
    int total = 0;
    int bad   = 0;
    int vec_id = 0;

    // Expected outputs for a state, written out from the state table.
    function automatic obs_t model(input int st, input bit mr, input bit z, input bit rn);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0:  begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr; end
            1:  begin o.aluSrcB = 2'b11; end
            2:  begin o.aluSrcA = 1; o.aluOp = 2'b10; end
            3:  begin o.regWrite = 1; o.regDst = 1; o.retire = 1; end
            4:  begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            5:  begin o.memRead = 1; o.iOrD = 1; end
            6:  begin o.regWrite = 1; o.memToReg = 1; o.retire = 1; end
            7:  begin o.memWrite = 1; o.iOrD = 1; o.retire = mr; end
            8:  begin o.aluSrcA = 1; o.aluOp = 2'b01; o.pcSrc = 1; o.pcWrite = z; o.retire = 1; end
            9:  begin o.illegalOp = 1; end
            10: begin o.busError = 1; end
            default: ;
        endcase
        if (!rn) begin
            o.pcWrite = 0; o.irWrite = 0; o.regWrite = 0;
            o.memWrite = 0; o.memRead = 0; o.retire = 0;
        end
        return o;
    endfunction

    // Drive one cycle's inputs, queue the expectation, advance past the edge.
    task automatic cyc(input int st, input bit mr, input bit z, input logic [5:0] op, input bit rn);
        sb_item_t it;
        rst_n        = rn;
        bus.memReady = mr;
        bus.zero     = z;
        bus.opCode   = op;
        it.exp = model(st, mr, z, rn);
        it.id  = vec_id;
        vec_id++;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    obs_t act;
    always_comb begin
        act = '0;
        act.st        = bus.state;
        act.pcWrite   = bus.pcWrite;
        act.pcSrc     = bus.pcSrc;
        act.irWrite   = bus.irWrite;
        act.iOrD      = bus.iOrD;
        act.memRead   = bus.memRead;
        act.memWrite  = bus.memWrite;
        act.memToReg  = bus.memToReg;
        act.regWrite  = bus.regWrite;
        act.regDst    = bus.regDst;
        act.aluSrcA   = bus.aluSrcA;
        act.aluSrcB   = bus.aluSrcB;
        act.aluOp     = bus.aluOp;
        act.retire    = bus.retire;
        act.illegalOp = bus.illegalOp;
        act.busError  = bus.busError;
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL vec%0d: got state=%0d outs=%05h, want state=%0d outs=%05h",
                         it.id, act.st, act[17:0], it.exp.st, it.exp[17:0]);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.memReady = 1'b1;
        bus.zero     = 1'b0;
        bus.opCode   = R;
        @(posedge clk);
        #1;

        // Held in reset: FETCH, strobes forced low.
        cyc(0, 1, 0, R, 0);

        // R-format, memReady high: 4 cycles.
        cyc(0, 1, 0, R, 1);
        cyc(1, 1, 0, R, 1);
        cyc(2, 1, 0, R, 1);
        cyc(3, 1, 0, R, 1);

        // LW with three memReady-low cycles in MEM_READ: 8 cycles.
        cyc(0, 1, 0, LW, 1);
        cyc(1, 1, 0, LW, 1);
        cyc(4, 1, 0, LW, 1);
        cyc(5, 0, 0, LW, 1);
        cyc(5, 0, 0, LW, 1);
        cyc(5, 0, 0, LW, 1);
        cyc(5, 1, 0, LW, 1);
        cyc(6, 1, 0, LW, 1);

        // BEQ taken, then not taken.
        cyc(0, 1, 1, BEQ, 1);
        cyc(1, 1, 1, BEQ, 1);
        cyc(8, 1, 1, BEQ, 1);
        cyc(0, 1, 0, BEQ, 1);
        cyc(1, 1, 0, BEQ, 1);
        cyc(8, 1, 0, BEQ, 1);

        // SW with one stall cycle in MEM_WRITE.
        cyc(0, 1, 0, SW, 1);
        cyc(1, 1, 0, SW, 1);
        cyc(4, 1, 0, SW, 1);
        cyc(7, 0, 0, SW, 1);
        cyc(7, 1, 0, SW, 1);

        // SW interrupted by reset mid-MEM_WRITE.
        cyc(0, 1, 0, SW, 1);
        cyc(1, 1, 0, SW, 1);
        cyc(4, 1, 0, SW, 1);
        cyc(7, 0, 0, SW, 0);

        // FETCH starved: 16 FETCH cycles, then BUS_ERR.
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, R, 1);
        for (int i = 0; i < 4; i++)  cyc(10, 1, 0, R, 1);

        // Reset out of BUS_ERR; memReady arrives on the 16th FETCH cycle.
        cyc(10, 0, 0, BAD, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, BAD, 1);
        cyc(0, 1, 0, BAD, 1);

        // Undefined opcode traps into ILLEGAL for 20 cycles.
        cyc(1, 1, 0, BAD, 1);
        for (int i = 0; i < 20; i++) cyc(9, 1, 0, BAD, 1);

        // One reset edge clears the trap; R-format runs again.
        cyc(9, 1, 0, R, 0);
        cyc(0, 1, 0, R, 1);
        cyc(1, 1, 0, R, 1);
        cyc(2, 1, 0, R, 1);
        cyc(3, 1, 0, R, 1);
        cyc(0, 0, 0, R, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
